sipo_rx: RTL

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_pkg.sv | 18 +
 rtl/sipo_if.sv | 28 ++
 rtl/sipo_out_buf.sv | 54 +++++
 rtl/sipo_rx.sv | 78 +++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and constants for the serial-in / parallel-out receiver.
//   sipo_state_t  : receiver FSM state (IDLE, SHIFT)
//   SIPO_DEFAULT_N: default word width in bits
//   count_width() : width of a bit counter that must hold values 0..n
package sipo_pkg;

  localparam int SIPO_DEFAULT_N = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sipo_if.sv
// sipo_if: bundle of the receiver's serial input, control and parallel output signals.
//   master: the producer/consumer side (drives serial data, strobes, out_ready)
//   slave : the receiver side (drives parallel_out, out_valid, busy, overrun)
interface sipo_if import sipo_pkg::*; #(
  parameter int N = SIPO_DEFAULT_N
) ();

  logic         serial_in;
  logic         sample_en;
  logic         frame_start;
  logic         clr_overrun;
  logic         out_ready;
  logic [N-1:0] parallel_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  modport master (
    output serial_in, sample_en, frame_start, clr_overrun, out_ready,
    input  parallel_out, out_valid, busy, overrun
  );

  modport slave (
    input  serial_in, sample_en, frame_start, clr_overrun, out_ready,
    output parallel_out, out_valid, busy, overrun
  );

endinterface

// File: rtl/sipo_out_buf.sv
// sipo_out_buf: one-entry output register with valid/ready handshake and a
// sticky overrun flag.
//   clk, rst_n   : clock, asynchronous active-low reset
//   word_done    : a complete word is offered on this edge
//   word_in      : the completed word
//   out_ready    : consumer accepts the held word when out_valid is high
//   clr_overrun  : synchronous clear of the overrun flag
//   parallel_out : held word (stable while out_valid is high)
//   out_valid    : parallel_out holds an unconsumed word
//   overrun      : a completed word was dropped because the entry was full
module sipo_out_buf import sipo_pkg::*; #(
  parameter int N = SIPO_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         word_done,
  input  logic [N-1:0] word_in,
  input  logic         out_ready,
  input  logic         clr_overrun,
  output logic [N-1:0] parallel_out,
  output logic         out_valid,
  output logic         overrun
);

  // The entry is full and nobody takes it this edge, so a new word must be dropped.
  logic blocked;
  assign blocked = out_valid && !out_ready;

  // A new word replaces the entry whenever it is empty or being consumed on
  // the same edge; a plain handshake without a new word empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
    end else if (word_done && !blocked) begin
      parallel_out <= word_in;
      out_valid    <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Setting on a dropped word takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (word_done && blocked) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in / parallel-out receiver, MSB first, framed by frame_start.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sipo_if slave modport
//     serial_in, sample_en, frame_start : serial data, sample strobe, word start marker
//     clr_overrun, out_ready            : overrun clear, consumer ready
//     parallel_out, out_valid           : assembled word and its valid flag
//     busy                              : a word is partially received
//     overrun                           : sticky dropped-word flag
module sipo_rx import sipo_pkg::*; #(
  parameter int N = SIPO_DEFAULT_N
) (
  input  logic clk,
  input  logic rst_n,
  sipo_if.slave bus
);

  localparam int CW = count_width(N);
  localparam int SW = N - 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  sipo_state_t   state;
  logic [CW-1:0] count;
  // Only the N-1 earlier bits are stored; the last bit goes straight to the output.
  logic [SW-1:0] shreg;

  logic         word_done;
  logic [N-1:0] word_next;
  logic [N-1:0] buf_word;
  logic         buf_valid;
  logic         buf_overrun;

  assign word_done = bus.sample_en && !bus.frame_start &&
                     (state == SHIFT) && (count == LAST_CNT);
  assign word_next = {shreg, bus.serial_in};

  // frame_start always restarts at count 1 with the current bit, whether idle
  // or mid-word; the Nth bit completes the word and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
    end else if (bus.sample_en) begin
      if (bus.frame_start) begin
        state <= SHIFT;
        count <= CW'(1);
        shreg <= SW'(bus.serial_in);
      end else if (state == SHIFT) begin
        if (word_done) begin
          state <= IDLE;
          count <= '0;
          shreg <= '0;
        end else begin
          count <= count + CW'(1);
          shreg <= SW'(word_next);
        end
      end
    end
  end

  sipo_out_buf #(.N(N)) u_out_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .word_done    (word_done),
    .word_in      (word_next),
    .out_ready    (bus.out_ready),
    .clr_overrun  (bus.clr_overrun),
    .parallel_out (buf_word),
    .out_valid    (buf_valid),
    .overrun      (buf_overrun)
  );

  assign bus.parallel_out = buf_word;
  assign bus.out_valid    = buf_valid;
  assign bus.overrun      = buf_overrun;
  assign bus.busy         = (state == SHIFT);

endmodule
